// File: rtl/f1_pkg.sv
// Shared types and default parameters for the F1 reaction-timer blocks.
package f1_pkg;

  typedef enum logic [1:0] {IDLE, FILL, HOLD, OUT} f1_state_t;

  localparam int DEF_N_LIGHTS = 8;
  localparam int DEF_DELAY_W  = 8;
  localparam int DEF_LFSR_W   = 8;

endpackage

// File: rtl/f1_delay_cnt.sv
// Loadable down-counter that times the hold between full lights and lights-out.
module f1_delay_cnt #(
  parameter int DELAY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic [DELAY_W-1:0] load_val,
  output logic               zero
);

  logic [DELAY_W-1:0] cnt;

  // Load wins over decrement; the sequencer never requests a decrement at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/f1_light_seq.sv
// Start-light sequencer: fills the light bar one lamp per tick, holds for a
// latched delay, then blanks the lights and pulses go for one clock.
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int N_LIGHTS = DEF_N_LIGHTS,
  parameter int DELAY_W  = DEF_DELAY_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                trigger,
  input  logic [DELAY_W-1:0]  delay,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                busy,
  output logic                go
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_FILL = FILL;
  localparam logic [1:0] ST_HOLD = HOLD;
  localparam logic [1:0] ST_OUT  = OUT;

  logic [1:0]         state;
  logic [DELAY_W-1:0] dly_q;
  logic               last_fill;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;

  // The tick that lights the final lamp is the one whose lower lamps are all lit.
  assign last_fill = &data_out[N_LIGHTS-2:0];
  assign cnt_load  = (state == ST_FILL) && en && last_fill;
  assign cnt_dec   = (state == ST_HOLD) && en && !cnt_zero;

  f1_delay_cnt #(
    .DELAY_W(DELAY_W)
  ) u_delay_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .load_val(dly_q),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      data_out <= '0;
      dly_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          data_out <= '0;
          if (trigger) begin
            state <= ST_FILL;
            dly_q <= delay;
          end
        end
        ST_FILL: begin
          if (en) begin
            data_out <= {data_out[N_LIGHTS-2:0], 1'b1};
            if (last_fill) state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (en && cnt_zero) begin
            state    <= ST_OUT;
            data_out <= '0;
          end
        end
        ST_OUT: begin
          state    <= ST_IDLE;
          data_out <= '0;
        end
        default: begin
          state    <= ST_IDLE;
          data_out <= '0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign go   = (state == ST_OUT);

endmodule

// File: tb/tb_f1_light_seq.sv
// Scoreboard bench for f1_light_seq: a reference model predicts each cycle,
// plus tick-count checks for nominal, zero-delay, re-trigger, reset and sweeps.
module tb_f1_light_seq;
  import f1_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       busy;
    logic       go;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, trigger;
  logic [7:0]  delay;
  logic [7:0]  data_out;
  logic        busy, go;

  logic        s_rst, s_en, s_trig;
  logic [7:0]  s_delay;
  logic [1:0]  d2;
  logic [31:0] d32;
  logic        busy2, go2, busy32, go32;

  int checks = 0;
  int errors = 0;

  exp_t       sb[$];
  f1_state_t  m_state = IDLE;
  logic [7:0] m_data  = '0;
  logic [7:0] m_cnt   = '0;
  logic [7:0] m_dly   = '0;

  always #5 clk = ~clk;

  f1_light_seq #(.N_LIGHTS(8), .DELAY_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .delay(delay),
    .data_out(data_out), .busy(busy), .go(go)
  );

  f1_light_seq #(.N_LIGHTS(2), .DELAY_W(8)) dut2 (
    .clk(clk), .rst(s_rst), .en(s_en), .trigger(s_trig), .delay(s_delay),
    .data_out(d2), .busy(busy2), .go(go2)
  );

  f1_light_seq #(.N_LIGHTS(32), .DELAY_W(8)) dut32 (
    .clk(clk), .rst(s_rst), .en(s_en), .trigger(s_trig), .delay(s_delay),
    .data_out(d32), .busy(busy32), .go(go32)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare.
  task automatic applyStimulus(input logic r, input logic e, input logic t, input logic [7:0] d);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; trigger = t; delay = d;
    if (!r) begin
      m_state = IDLE; m_data = '0; m_cnt = '0; m_dly = '0;
    end else begin
      case (m_state)
        IDLE: if (t) begin m_state = FILL; m_dly = d; end
        FILL: if (e) begin
          if (m_data == 8'h7F) begin m_state = HOLD; m_cnt = m_dly; end
          m_data = {m_data[6:0], 1'b1};
        end
        HOLD: if (e) begin
          if (m_cnt == 8'd0) begin m_state = OUT; m_data = '0; end
          else m_cnt = m_cnt - 8'd1;
        end
        default: m_state = IDLE;
      endcase
    end
    x.data = m_data; x.busy = (m_state != IDLE); x.go = (m_state == OUT);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checkOutput("data_out", {56'd0, data_out}, {56'd0, x.data});
    checkOutput("busy", {63'd0, busy}, {63'd0, x.busy});
    checkOutput("go", {63'd0, go}, {63'd0, x.go});
  endtask

  task automatic runSequence(input int dly, input int period, input bit retrig,
                             input bit mid_reset, input int exp_ticks);
    int  ticks = 0;
    int  gos   = 0;
    bit  done  = 0;
    logic r, e, t;
    applyStimulus(1'b1, period == 1, 1'b1, dly[7:0]);
    for (int c = 0; c < 400 && !done; c++) begin
      e = ((c % period) == period - 1);
      r = 1'b1;
      t = 1'b0;
      if (retrig && m_state == FILL && m_data == 8'h07) t = 1'b1;
      if (retrig && m_state == HOLD && m_cnt == 8'd1) t = 1'b1;
      if (mid_reset && m_data == 8'h1F) r = 1'b0;
      if (e && r) ticks++;
      applyStimulus(r, e, t, 8'($urandom));
      if (go) begin
        gos++;
        if (gos == 1) checkOutput("ticks_to_go", ticks, exp_ticks);
      end
      if (mid_reset && !r) begin
        checkOutput("midrst_data", {56'd0, data_out}, 64'd0);
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        done = 1;
      end
      if (gos > 0 && !busy) done = 1;
    end
    if (!mid_reset) checkOutput("go_count", gos, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cnt;
    bit  seen2, seen32;
    logic [1:0]  last2;
    logic [31:0] last32;

    rst = 1'b0; en = 1'b0; trigger = 1'b0; delay = '0;
    s_rst = 1'b0; s_en = 1'b0; s_trig = 1'b0; s_delay = '0;

    applyStimulus(1'b0, 1'b1, 1'b1, 8'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);

    $display("[TB] nominal run, delay 3, en every 4th cycle");
    runSequence(3, 4, 1'b0, 1'b0, 8 + 3 + 1);
    $display("[TB] zero delay, en tied high");
    runSequence(0, 1, 1'b0, 1'b0, 8 + 0 + 1);
    $display("[TB] re-trigger during fill and hold");
    runSequence(3, 4, 1'b1, 1'b0, 8 + 3 + 1);
    $display("[TB] mid-sequence reset then restart");
    runSequence(3, 2, 1'b0, 1'b1, 0);
    runSequence(3, 4, 1'b0, 1'b0, 8 + 3 + 1);

    $display("[TB] parameter sweep N=2 and N=32, delay 255");
    repeat (2) @(negedge clk);
    @(negedge clk);
    s_rst = 1'b1; s_en = 1'b1; s_trig = 1'b1; s_delay = 8'd255;
    @(negedge clk);
    s_trig = 1'b0;
    s_delay = 8'd7;
    cnt = 1; seen2 = 0; seen32 = 0; last2 = '0; last32 = '0;
    for (int c = 0; c < 400 && !(seen2 && seen32); c++) begin
      last2 = d2; last32 = d32;
      @(posedge clk);
      #1;
      if (go2 && !seen2) begin
        seen2 = 1;
        checkOutput("sweep2_ticks", cnt, 2 + 255 + 1);
        checkOutput("sweep2_pattern", {62'd0, last2}, 64'h3);
      end
      if (go32 && !seen32) begin
        seen32 = 1;
        checkOutput("sweep32_ticks", cnt, 32 + 255 + 1);
        checkOutput("sweep32_pattern", {32'd0, last32}, 64'hFFFF_FFFF);
      end
      cnt++;
    end
    checkOutput("sweep2_go_seen", {63'd0, seen2}, 64'd1);
    checkOutput("sweep32_go_seen", {63'd0, seen32}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
